sum_collector: RTL and testbench
================================

// Module: sum_collector
// PURPOSE
//   Result stage directly downstream of the 4-bit registered adder.
//   - Captures each {Overflow,Sum} result the adder produces into a small first-word-fall-through FIFO.
//   - Keeps a wide running total of all accepted results.
//   - Counts results lost while the FIFO is full.
//   The adder has no backpressure, so this block absorbs bursts and hands results to the consumer on a valid/ready port.
// PARAMETERS
//   WIDTH    4   operand/sum width of the upstream adder
//   DEPTH    4   FIFO entries; power of two, >= 2
//   TOTAL_W  12  width of running total Total
// PORTS
//   Clk         in   1            single clock; all state updates on posedge Clk
//   Reset       in   1            synchronous, active-high reset
//   In_Valid    in   1            adder result valid this cycle (adder En delayed one cycle by the integrator)
//   Sum         in   WIDTH        adder Sum
//   Overflow    in   1            adder Overflow (carry-out)
//   Out_Ready   in   1            consumer accepts head entry
//   Out_Valid   out  1            FIFO non-empty
//   Out_Data    out  WIDTH+1      head entry {Overflow,Sum}
//   Full        out  1            Count == DEPTH
//   Empty       out  1            Count == 0
//   Count       out  clog2(DEPTH)+1  occupancy
//   Total       out  TOTAL_W      running sum of accepted results
//   Drop_Count  out  8            results discarded while full
//   Ovf_Count   out  8            only with SUM_COLLECTOR_OVF_CNT_EN
// BEHAVIOUR
//   Reset (sync, dominates everything, also mid-burst):
//     - Count, read/write pointers, Total, Drop_Count and Ovf_Count go to 0.
//     - Hence Out_Valid=0, Empty=1, Full=0. FIFO storage need not be cleared.
//   pop  = Out_Valid & Out_Ready.
//   push = In_Valid & (!Full | pop). Simultaneous push+pop while full is legal: Count unchanged.
//   Out_Data is the head entry combinationally (FWFT): a push into an empty FIFO gives Out_Valid=1 the next cycle.
//   Latency In_Valid -> Out_Valid is 1 cycle when empty.
//   Out_Data is X-don't-care when Out_Valid=0. Out_Ready while empty has no effect.
//   Pointers wrap modulo DEPTH. Count is the occupancy and separates full from empty.
//   Total: on push, Total <= Total + zero-extended {Overflow,Sum}, wrapping modulo 2^TOTAL_W.
//   Drop: In_Valid & Full & !pop -> entry discarded; Total unchanged; Drop_Count increments, saturating at 8'hFF.
//   Out_Valid, Full, Empty and Count are derived from registered Count only; no combinational path In_Valid->Out_Valid.
//   Out_Ready may combinationally affect nothing but pop.
// CONFIGURATION
//   SUM_COLLECTOR_OVF_CNT_EN defined:
//     - Ovf_Count port exists; on each push with Overflow=1 it increments, saturating at 8'hFF.
//   Not defined:
//     - Ovf_Count port and counter absent. All other behaviour is identical.
// STRUCTURE
//   Shared package adder_pkg:
//     - OPERAND_W=4.
//     - Result entry layout: bit WIDTH = overflow, [WIDTH-1:0] = sum.
//     - Saturation constant CNT_MAX=8'hFF.
//   Sub-module sync_fifo (WIDTH+1 data, DEPTH entries, FWFT, push/pop/count).
//     - Top level holds the push/drop decision, Total and the counters.
// TESTING
//   1. Reset=1 two cycles, then idle -> Out_Valid=0, Empty=1, Count=0, Total=0, Drop_Count=0.
//   2. In_Valid one cycle with Sum=4'h9, Overflow=1, Out_Ready=0 -> next cycle Out_Valid=1, Out_Data=5'h19, Total=25, Count=1.
//   3. Out_Ready=0, push 6 results 1..6 -> Full=1 after 4; Count=4; Drop_Count=2; Total=10.
//      Then Out_Ready=1 drains 1,2,3,4 in order, then Empty=1.
//   4. Full, then In_Valid=1 with Out_Ready=1 the same cycle -> pop+push; Count stays 4; Drop_Count unchanged; new entry appears last.
//   5. Push 5'h1F 400 times with continuous drain (TOTAL_W=12) -> Total=12400 mod 4096=112; no drops.
//   6. Reset asserted with Count=3 and In_Valid=1 -> next cycle Count=0, Out_Valid=0, Total=0.
//      Build with SUM_COLLECTOR_OVF_CNT_EN: 300 pushes with Overflow=1 -> Ovf_Count=8'hFF.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the 4-bit registered adder and its result stage.
// Result entries are packed as {overflow, sum}.
package adder_pkg;

   localparam int OPERAND_W = 4;
   localparam int OVF_BIT = OPERAND_W;
   localparam logic [7:0] CNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == CNT_MAX) begin
         return value;
      end else begin
         return value + 8'd1;
      end
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is visible on rd_data_s whenever count_r is non-zero.
module sync_fifo
   import adder_pkg::*;
#(
   parameter int DATA_W = OPERAND_W + 1,
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     push_s,
   input  logic                     pop_s,
   input  logic [DATA_W-1:0]        wr_data_s,
   output logic [DATA_W-1:0]        rd_data_s,
   output logic [$clog2(DEPTH):0]   count_r
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;

   // Storage write; contents need no reset because count_r gates visibility.
   always_ff @(posedge Clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data_s;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data_s = mem_r[rd_ptr_r];

endmodule

// File: rtl/sum_collector.sv
// Result stage behind the registered adder: FWFT buffering, running total and drop count.
// Optional overflow counter enabled by defining SUM_COLLECTOR_OVF_CNT_EN.
module sum_collector
   import adder_pkg::*;
#(
   parameter int WIDTH = OPERAND_W,
   parameter int DEPTH = 4,
   parameter int TOTAL_W = 12
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     In_Valid,
   input  logic [WIDTH-1:0]         Sum,
   input  logic                     Overflow,
   input  logic                     Out_Ready,
   output logic                     Out_Valid,
   output logic [WIDTH:0]           Out_Data,
   output logic                     Full,
   output logic                     Empty,
   output logic [$clog2(DEPTH):0]   Count,
   output logic [TOTAL_W-1:0]       Total,
   output logic [7:0]               Drop_Count
`ifdef SUM_COLLECTOR_OVF_CNT_EN
   ,
   output logic [7:0]               Ovf_Count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]      count_s;
   logic [WIDTH:0]     entry_s;
   logic               push_s;
   logic               pop_s;
   logic               drop_s;
   logic [TOTAL_W-1:0] total_r;
   logic [7:0]         drop_cnt_r;

   // Status flags come only from the registered occupancy.
   assign Empty     = (count_s == {CW{1'b0}});
   assign Full      = (count_s == CW'(DEPTH));
   assign Out_Valid = !Empty;
   assign Count     = count_s;

   assign entry_s = {Overflow, Sum};
   assign pop_s   = Out_Valid & Out_Ready;
   assign push_s  = In_Valid & (!Full | pop_s);
   assign drop_s  = In_Valid & Full & !pop_s;

   sync_fifo #(
      .DATA_W (WIDTH + 1),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .push_s    (push_s),
      .pop_s     (pop_s),
      .wr_data_s (entry_s),
      .rd_data_s (Out_Data),
      .count_r   (count_s)
   );

   // Running total of accepted entries and saturating drop counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         total_r    <= {TOTAL_W{1'b0}};
         drop_cnt_r <= 8'h00;
      end else begin
         if (push_s) begin
            total_r <= total_r + TOTAL_W'(entry_s);
         end
         if (drop_s) begin
            drop_cnt_r <= sat_inc8(drop_cnt_r);
         end
      end
   end

   assign Total      = total_r;
   assign Drop_Count = drop_cnt_r;

`ifdef SUM_COLLECTOR_OVF_CNT_EN
   logic [7:0] ovf_cnt_r;

   // Counts accepted entries that carried an adder overflow.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ovf_cnt_r <= 8'h00;
      end else if (push_s && Overflow) begin
         ovf_cnt_r <= sat_inc8(ovf_cnt_r);
      end
   end

   assign Ovf_Count = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_sum_collector.sv
// Directed bench for sum_collector: vector table plus multi-cycle sequences.
module tb_sum_collector;

   logic       Clk;
   logic       Reset;
   logic       In_Valid;
   logic [3:0] Sum;
   logic       Overflow;
   logic       Out_Ready;
   logic       Out_Valid;
   logic [4:0] Out_Data;
   logic       Full;
   logic       Empty;
   logic [2:0] Count;
   logic [11:0] Total;
   logic [7:0] Drop_Count;
`ifdef SUM_COLLECTOR_OVF_CNT_EN
   logic [7:0] Ovf_Count;
`endif

   int checks = 0;
   int errors = 0;

   sum_collector dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .In_Valid   (In_Valid),
      .Sum        (Sum),
      .Overflow   (Overflow),
      .Out_Ready  (Out_Ready),
      .Out_Valid  (Out_Valid),
      .Out_Data   (Out_Data),
      .Full       (Full),
      .Empty      (Empty),
      .Count      (Count),
      .Total      (Total),
      .Drop_Count (Drop_Count)
`ifdef SUM_COLLECTOR_OVF_CNT_EN
      ,
      .Ovf_Count  (Ovf_Count)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic       iv;
      logic [3:0] sum;
      logic       ovf;
      logic       rdy;
      logic       e_valid;
      logic [2:0] e_count;
      logic [11:0] e_total;
      logic [7:0] e_drop;
      logic [4:0] e_data;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic iv, input logic [3:0] sum, input logic ovf,
                               input logic rdy, input logic e_valid, input logic [2:0] e_count,
                               input logic [11:0] e_total, input logic [7:0] e_drop,
                               input logic [4:0] e_data);
      vec_t v;
      v.iv = iv; v.sum = sum; v.ovf = ovf; v.rdy = rdy;
      v.e_valid = e_valid; v.e_count = e_count; v.e_total = e_total;
      v.e_drop = e_drop; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [3:0] sum, input logic ovf, input logic rdy);
      In_Valid  = iv;
      Sum       = sum;
      Overflow  = ovf;
      Out_Ready = rdy;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // iv sum ovf rdy | valid count total drop data
      vecs[0]  = mk(1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 3'd1, 12'd25, 8'd0, 5'h19);
      vecs[1]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 12'd25, 8'd0, 5'h00);
      vecs[2]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 12'd25, 8'd0, 5'h00);
      vecs[3]  = mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 3'd1, 12'd26, 8'd0, 5'h01);
      vecs[4]  = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 3'd2, 12'd28, 8'd0, 5'h01);
      vecs[5]  = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 3'd3, 12'd31, 8'd0, 5'h01);
      vecs[6]  = mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 3'd4, 12'd35, 8'd0, 5'h01);
      vecs[7]  = mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 3'd4, 12'd35, 8'd1, 5'h01);
      vecs[8]  = mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 3'd4, 12'd35, 8'd2, 5'h01);
      vecs[9]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd3, 12'd35, 8'd2, 5'h02);
      vecs[10] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd2, 12'd35, 8'd2, 5'h03);
      vecs[11] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd1, 12'd35, 8'd2, 5'h04);
      vecs[12] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 12'd35, 8'd2, 5'h00);
      vecs[13] = mk(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 3'd1, 12'd42, 8'd2, 5'h07);
      vecs[14] = mk(1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 3'd2, 12'd50, 8'd2, 5'h07);
      vecs[15] = mk(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 3'd3, 12'd59, 8'd2, 5'h07);
      vecs[16] = mk(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 3'd4, 12'd69, 8'd2, 5'h07);
      vecs[17] = mk(1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 3'd4, 12'd80, 8'd2, 5'h08);
      vecs[18] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd3, 12'd80, 8'd2, 5'h09);
      vecs[19] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd2, 12'd80, 8'd2, 5'h0A);
      vecs[20] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 3'd1, 12'd80, 8'd2, 5'h0B);
      vecs[21] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 12'd80, 8'd2, 5'h00);
      vecs[22] = mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 3'd1, 12'd82, 8'd2, 5'h02);
      vecs[23] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 12'd82, 8'd2, 5'h00);

      // Reset for two cycles, then one idle cycle
      Reset = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      tick();
      Reset = 1'b0;
      tick();
      chk("rst_valid", 32'(Out_Valid), 32'd0);
      chk("rst_empty", 32'(Empty), 32'd1);
      chk("rst_full", 32'(Full), 32'd0);
      chk("rst_count", 32'(Count), 32'd0);
      chk("rst_total", 32'(Total), 32'd0);
      chk("rst_drop", 32'(Drop_Count), 32'd0);
`ifdef SUM_COLLECTOR_OVF_CNT_EN
      chk("rst_ovf", 32'(Ovf_Count), 32'd0);
`endif

      // Table-driven sequence: capture, fill, drop, drain, pop+push while full
      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].iv, vecs[i].sum, vecs[i].ovf, vecs[i].rdy);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(Out_Valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d_count", i), 32'(Count), 32'(vecs[i].e_count));
         chk($sformatf("v%0d_total", i), 32'(Total), 32'(vecs[i].e_total));
         chk($sformatf("v%0d_drop", i), 32'(Drop_Count), 32'(vecs[i].e_drop));
         chk($sformatf("v%0d_full", i), 32'(Full), 32'(vecs[i].e_count == 3'd4));
         chk($sformatf("v%0d_empty", i), 32'(Empty), 32'(vecs[i].e_count == 3'd0));
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_data", i), 32'(Out_Data), 32'(vecs[i].e_data));
         end
      end

      // Total wraps modulo 4096: 400 * 31 = 12400 -> 112
      Reset = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 400; i++) begin
         drive(1'b1, 4'hF, 1'b1, 1'b1);
         tick();
`ifdef SUM_COLLECTOR_OVF_CNT_EN
         if (i == 9) chk("ovf_mid", 32'(Ovf_Count), 32'd10);
`endif
      end
      chk("wrap_total", 32'(Total), 32'd112);
      chk("wrap_drop", 32'(Drop_Count), 32'd0);
      chk("wrap_count", 32'(Count), 32'd1);
      chk("wrap_data", 32'(Out_Data), 32'h1F);
`ifdef SUM_COLLECTOR_OVF_CNT_EN
      chk("ovf_sat", 32'(Ovf_Count), 32'hFF);
`endif

      // Reset mid-burst with three entries held and In_Valid high
      Reset = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 1), 1'b0, 1'b0);
         tick();
      end
      chk("pre_rst_count", 32'(Count), 32'd3);
      chk("pre_rst_total", 32'(Total), 32'd6);
      Reset = 1'b1;
      drive(1'b1, 4'h5, 1'b1, 1'b0);
      tick();
      chk("mid_rst_count", 32'(Count), 32'd0);
      chk("mid_rst_valid", 32'(Out_Valid), 32'd0);
      chk("mid_rst_total", 32'(Total), 32'd0);
      chk("mid_rst_empty", 32'(Empty), 32'd1);
      Reset = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
